// File: rtl/image_row_loader_pkg.sv
// -----------------------------------------------------------------------------
// image_row_loader_pkg
//   Shared constants and types for the image row loader: pixel/row geometry,
//   buffer region encodings, the loader FSM state type and the row-count clamp.
// -----------------------------------------------------------------------------
package image_row_loader_pkg;

   localparam int PIX_W    = 24;              // bits per pixel (RGB888)
   localparam int ROW_PIX  = 128;             // pixels per row
   localparam int ROW_W    = PIX_W * ROW_PIX; // packed row width (3072)
   localparam int MAX_ROWS = 128;             // rows per buffer region

   localparam int CNT_W    = 7;               // pixel / row index width
   localparam int ROWS_W   = 8;               // row count width (0..255 in)
   localparam int REGION_W = 2;
   localparam int ADDR_W   = REGION_W + CNT_W;

   // Buffer region encodings (driven onto waddr[8:7])
   localparam logic [REGION_W-1:0] REGION_0 = 2'd0;
   localparam logic [REGION_W-1:0] REGION_1 = 2'd1;
   localparam logic [REGION_W-1:0] REGION_2 = 2'd2;
   localparam logic [REGION_W-1:0] REGION_3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } loader_state_t;

   // A region only holds MAX_ROWS rows; larger requests are trimmed.
   function automatic logic [ROWS_W-1:0] clamp_rows(input logic [ROWS_W-1:0] n);
      return (n > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : n;
   endfunction

endpackage

// File: rtl/image_row_loader_row_packer.sv
// -----------------------------------------------------------------------------
// image_row_loader_row_packer
//   Packs a stream of pixels into one row register. Pixel k of the row is
//   stored at bits [PIX_W*k +: PIX_W], so pixel 0 sits in the LSBs.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (counter only)
//   i_clear     : return the pixel counter to 0 (new row / discard partial)
//   i_load      : store i_pix at the current slot and advance the counter
//   i_pix       : pixel data
//   o_row       : packed row contents
//   o_last      : counter is at the final slot of the row
// -----------------------------------------------------------------------------
module image_row_loader_row_packer
   import image_row_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [PIX_W-1:0] i_pix,
   output logic [ROW_W-1:0] o_row,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;
   logic [ROW_W-1:0] r_row;

   // The counter is 7 bits wide, so the increment after slot 127 wraps to 0
   // and the next row starts without an explicit clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Row storage is fully overwritten every row, so it carries no reset.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_row[int'(r_cnt) * PIX_W +: PIX_W] <= i_pix;
      end
   end

   assign o_row  = r_row;
   assign o_last = (r_cnt == CNT_W'(ROW_PIX - 1));

endmodule

// File: rtl/image_row_loader.sv
// -----------------------------------------------------------------------------
// image_row_loader
//   Accepts an RGB888 pixel stream over valid/ready, packs 128 pixels per row
//   and writes each completed row into a selected 128-row region of the image
//   buffer with a single-cycle write strobe. Signals completion with a pulse.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a load when idle
//   abort      : cancels the current load (no further write, no done)
//   region     : buffer region, latched at start, drives waddr[8:7]
//   num_rows   : rows to load, latched at start (0 = none, >128 clamps to 128)
//   pix_in     : pixel data
//   pix_valid  : pix_in is valid
//   pix_ready  : loader accepts a pixel this cycle
//   we         : buffer write strobe
//   waddr      : {region, row[6:0]}
//   wdata      : packed row
//   busy       : load in progress (cycle after accepted start until idle)
//   done       : one-cycle pulse after the final row write
// -----------------------------------------------------------------------------
module image_row_loader
   import image_row_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [REGION_W-1:0] region,
   input  logic [ROWS_W-1:0]   num_rows,
   input  logic [PIX_W-1:0]    pix_in,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic                we,
   output logic [ADDR_W-1:0]   waddr,
   output logic [ROW_W-1:0]    wdata,
   output logic                busy,
   output logic                done
);

   loader_state_t       r_state;
   loader_state_t       w_state_nxt;

   logic [REGION_W-1:0] r_region;
   logic [ROWS_W-1:0]   r_rows;
   logic [CNT_W-1:0]    r_row;
   logic [ADDR_W-1:0]   r_waddr_hold;
   logic [ROW_W-1:0]    r_wdata_hold;

   logic [ROWS_W-1:0]   w_rows_clamped;
   logic                w_start_load;
   logic                w_ready;
   logic                w_load;
   logic                w_we;
   logic                w_last_pix;
   logic                w_last_row;
   logic                w_pk_clear;
   logic [ROW_W-1:0]    w_row_data;
   logic [ADDR_W-1:0]   w_addr_cur;

   assign w_rows_clamped = clamp_rows(num_rows);
   assign w_start_load   = (r_state == ST_IDLE) && start && (w_rows_clamped != '0);

   assign w_ready    = (r_state == ST_FILL);
   // A pixel presented alongside abort belongs to a discarded row; drop it.
   assign w_load     = w_ready && pix_valid && !abort;
   // abort wins over the write cycle, so a cancelled WRITE never strobes.
   assign w_we       = (r_state == ST_WRITE) && !abort;
   assign w_last_row = (({1'b0, r_row} + 8'd1) == r_rows);
   // Holding the counter clear while idle guarantees every load starts at slot 0.
   assign w_pk_clear = (r_state == ST_IDLE) || abort;
   assign w_addr_cur = {r_region, r_row};

   image_row_loader_row_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_pk_clear),
      .i_load  (w_load),
      .i_pix   (pix_in),
      .o_row   (w_row_data),
      .o_last  (w_last_pix)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (w_rows_clamped == '0) ? ST_FINISH : ST_FILL;
            end
         end
         ST_FILL: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_load && w_last_pix) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last_row) begin
               w_state_nxt = ST_FINISH;
            end else begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Load parameters and row sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_region <= '0;
         r_rows   <= '0;
         r_row    <= '0;
      end else if (w_start_load) begin
         r_region <= region;
         r_rows   <= w_rows_clamped;
         r_row    <= '0;
      end else if (w_we) begin
         r_row    <= r_row + 1'b1;
      end
   end

   // Last-written address/data, so the write port holds steady between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waddr_hold <= '0;
         r_wdata_hold <= '0;
      end else if (w_we) begin
         r_waddr_hold <= w_addr_cur;
         r_wdata_hold <= w_row_data;
      end
   end

   assign pix_ready = w_ready;
   assign we        = w_we;
   assign waddr     = w_we ? w_addr_cur : r_waddr_hold;
   assign wdata     = w_we ? w_row_data : r_wdata_hold;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FINISH);

endmodule

// File: tb/tb_image_row_loader.sv
module tb_image_row_loader;

   localparam int PW = 24;
   localparam int RP = 128;
   localparam int RW = PW * RP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    region = 2'd0;
   logic [7:0]    num_rows = 8'd0;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic          we;
   logic [8:0]    waddr;
   logic [RW-1:0] wdata;
   logic          busy;
   logic          done;

   image_row_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .region    (region),
      .num_rows  (num_rows),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed writes and done pulses
   logic [8:0]    wa_q[$];
   logic [RW-1:0] wd_q[$];
   int            wc_q[$];
   int            done_cnt;
   int            done_cyc;
   int            viol;

   // Reference: every accepted pixel in order; rows are consecutive groups of 128
   logic [PW-1:0] acc_q[$];
   int            first_acc;
   int            last_acc;
   logic [RW-1:0] single_wdata;

   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            wc_q.push_back(cyc);
            if (pix_ready) viol++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
      done_cnt = 0; done_cyc = -1; viol = 0; first_acc = -1; last_acc = -1;
   endtask

   task automatic do_start(input logic [1:0] rg, input logic [7:0] n);
      region = rg; num_rows = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
   // kind: 0 pixel = index within row, 1 all ones, 2 random
   task automatic push(input int n, input int mode, input int kind);
      logic [PW-1:0] p;
      int gap, t;
      for (int i = 0; i < n; i++) begin
         gap = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
         if (gap > 0) begin
            pix_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         case (kind)
            0:       p = PW'(acc_q.size() % RP);
            1:       p = '1;
            default: p = PW'($urandom);
         endcase
         pix_in = p; pix_valid = 1'b1;
         t = 0;
         while (!pix_ready && t < 1000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL push_timeout: pix_ready low for %0d cycles, required high", t);
            pix_valid = 1'b0;
            return;
         end
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
         @(negedge clk);
         acc_q.push_back(p);
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int t = 0;
      while (busy && t < limit) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, t);
      end
      repeat (2) @(negedge clk);
   endtask

   // Compare observed writes with rows built from the accepted pixel stream
   task automatic check_writes(input string tag, input logic [1:0] rg, input int nrows);
      logic [RW-1:0] exp_row;
      logic [8:0]    exp_addr;
      int            bad;
      checks++;
      if (wa_q.size() != nrows) begin
         errors++;
         $display("FAIL %s_count: writes=%0d required %0d", tag, wa_q.size(), nrows);
      end
      for (int r = 0; r < nrows && r < wa_q.size(); r++) begin
         exp_addr = {rg, 7'(r)};
         checks++;
         if (wa_q[r] !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr row %0d: waddr=%03h required %03h", tag, r, wa_q[r], exp_addr);
         end
         exp_row = '0;
         for (int k = 0; k < RP; k++)
            if (r * RP + k < acc_q.size()) exp_row[k*PW +: PW] = acc_q[r*RP + k];
         checks++;
         if (wd_q[r] !== exp_row) begin
            errors++;
            bad = 0;
            for (int k = RP - 1; k >= 0; k--)
               if (wd_q[r][k*PW +: PW] !== exp_row[k*PW +: PW]) bad = k;
            $display("FAIL %s_data row %0d pixel %0d: got %06h required %06h",
                     tag, r, bad, wd_q[r][bad*PW +: PW], exp_row[bad*PW +: PW]);
         end
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_int("reset_pix_ready_in", int'(pix_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_int("reset_pix_ready", int'(pix_ready), 0);
      check_int("reset_we", int'(we), 0);
      check_int("reset_waddr", int'(waddr), 0);
      checks++;
      if (wdata !== '0) begin
         errors++;
         $display("FAIL reset_wdata: nonzero (low word %06h), required 0", wdata[PW-1:0]);
      end
      check_int("reset_busy", int'(busy), 0);
      check_int("reset_done", int'(done), 0);
   endtask

   task automatic test_single_row();
      clear_obs();
      do_start(2'd1, 8'd1);
      check_int("single_busy_after_start", int'(busy), 1);
      push(RP, 0, 0);
      wait_idle(50);
      check_writes("single", 2'd1, 1);
      if (wa_q.size() > 0) begin
         check_int("single_waddr_080", int'(wa_q[0]), 'h080);
         check_int("single_first_to_we", wc_q[0] - first_acc, RP);
         check_int("single_last_to_we", wc_q[0] - last_acc, 1);
         check_int("single_done_next", done_cyc, wc_q[0] + 1);
         single_wdata = wd_q[0];
      end
      check_int("single_done_cnt", done_cnt, 1);
      check_int("single_ready_we_overlap", viol, 0);
   endtask

   task automatic test_multi_row();
      clear_obs();
      do_start(2'd2, 8'd3);
      push(3 * RP, 0, 1);
      wait_idle(50);
      check_writes("multi", 2'd2, 3);
      for (int r = 0; r < 3 && r < wd_q.size(); r++) begin
         checks++;
         if (wd_q[r] !== {RW{1'b1}}) begin
            errors++;
            $display("FAIL multi_ones row %0d: low word %06h required ffffff", r, wd_q[r][PW-1:0]);
         end
      end
      check_int("multi_done_cnt", done_cnt, 1);
      check_int("multi_ready_we_overlap", viol, 0);
   endtask

   task automatic test_bursty();
      clear_obs();
      do_start(2'd1, 8'd1);
      push(RP, 1, 0);
      wait_idle(50);
      check_writes("bursty", 2'd1, 1);
      if (wa_q.size() > 0) begin
         checks++;
         if (wd_q[0] !== single_wdata) begin
            errors++;
            $display("FAIL bursty_vs_single: low word %06h required %06h", wd_q[0][PW-1:0], single_wdata[PW-1:0]);
         end
         check_int("bursty_last_to_we", wc_q[0] - last_acc, 1);
      end
      check_int("bursty_done_cnt", done_cnt, 1);
   endtask

   task automatic test_random();
      logic [1:0] rg;
      int n;
      for (int it = 0; it < 3; it++) begin
         clear_obs();
         rg = 2'($urandom);
         n = int'($urandom_range(1, 3));
         do_start(rg, 8'(n));
         push(n * RP, 2, 2);
         wait_idle(50);
         check_writes("random", rg, n);
         check_int("random_done_cnt", done_cnt, 1);
         check_int("random_ready_we_overlap", viol, 0);
      end
   endtask

   task automatic test_abort();
      clear_obs();
      do_start(2'd3, 8'd2);
      push(RP + 60, 0, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      check_int("abort_busy_low", int'(busy), 0);
      repeat (5) @(negedge clk);
      check_writes("abort", 2'd3, 1);
      check_int("abort_no_done", done_cnt, 0);
      clear_obs();
      do_start(2'd0, 8'd1);
      push(RP, 0, 2);
      wait_idle(50);
      check_writes("abort_restart", 2'd0, 1);
      check_int("abort_restart_done", done_cnt, 1);
   endtask

   task automatic test_zero_rows();
      int s;
      clear_obs();
      s = cyc;
      do_start(2'd2, 8'd0);
      repeat (4) @(negedge clk);
      check_int("zero_done_cnt", done_cnt, 1);
      checks++;
      if (done_cyc < s || done_cyc - s > 2) begin
         errors++;
         $display("FAIL zero_done_latency: %0d cycles, required at most 2", done_cyc - s);
      end
      check_int("zero_no_we", wa_q.size(), 0);
      check_int("zero_idle", int'(busy), 0);
   endtask

   task automatic test_start_while_busy();
      clear_obs();
      do_start(2'd0, 8'd2);
      push(50, 0, 2);
      do_start(2'd3, 8'd1);
      check_int("busy_start_busy", int'(busy), 1);
      push(2 * RP - 50, 0, 2);
      wait_idle(50);
      check_writes("busy_start", 2'd0, 2);
      check_int("busy_start_done", done_cnt, 1);
   endtask

   task automatic test_clamp();
      clear_obs();
      do_start(2'd1, 8'd200);
      push(RP * RP, 0, 2);
      wait_idle(50);
      check_writes("clamp", 2'd1, RP);
      if (wa_q.size() > 0) check_int("clamp_last_addr", int'(wa_q[$]), 'h0FF);
      check_int("clamp_done_cnt", done_cnt, 1);
      check_int("clamp_ready_we_overlap", viol, 0);
   endtask

   task automatic test_reset_mid_fill();
      clear_obs();
      do_start(2'd1, 8'd1);
      push(100, 0, 2);
      pix_in = 24'h123456; pix_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_int("rst_mid_pix_ready", int'(pix_ready), 0);
      check_int("rst_mid_we", int'(we), 0);
      check_int("rst_mid_busy", int'(busy), 0);
      check_int("rst_mid_done", int'(done), 0);
      check_int("rst_mid_waddr", int'(waddr), 0);
      checks++;
      if (wdata !== '0) begin
         errors++;
         $display("FAIL rst_mid_wdata: nonzero (low word %06h), required 0", wdata[PW-1:0]);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_int("rst_mid_no_we", wa_q.size(), 0);
      clear_obs();
      do_start(2'd2, 8'd1);
      push(RP, 0, 0);
      wait_idle(50);
      check_writes("rst_restart", 2'd2, 1);
      check_int("rst_restart_done", done_cnt, 1);
   endtask

   initial begin
      clear_obs();
      single_wdata = '0;
      test_reset();
      test_single_row();
      test_multi_row();
      test_bursty();
      test_random();
      test_abort();
      test_zero_rows();
      test_start_while_busy();
      test_clamp();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
